divider_signed_iterative: RTL and testbench

DIVIDER_SIGNED_ITERATIVE -- requirements
Module: divider_signed_iterative

---
 rtl/divider_signed_iterative.sv | 146 ++++++++++++++
 tb/tb_divider_signed_iterative.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/divider_signed_iterative.sv
// Iterative signed/unsigned divider: one non-restoring quotient bit per cycle,
// then a single fix-up cycle for remainder restore and sign correction.
module divider_signed_iterative #(
    parameter int unsigned WORD_WIDTH = 36
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    input  logic                  is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int unsigned CntW = $clog2(WORD_WIDTH + 1);
    localparam logic [CntW-1:0] IterCount = CntW'(WORD_WIDTH);
    localparam logic [WORD_WIDTH-1:0] MostNeg = {1'b1, {(WORD_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e                state_q, state_d;
    logic                  ready_q;
    logic [CntW-1:0]       cnt_q;
    logic [WORD_WIDTH:0]   part_q;
    logic [WORD_WIDTH-1:0] quo_q;
    logic [WORD_WIDTH-1:0] dvs_q;
    logic                  neg_quo_q, neg_rem_q;
    logic [WORD_WIDTH-1:0] quot_res_q, rem_res_q;
    logic                  dbz_q, ovf_q;

    logic                  accept;
    logic                  dividend_neg, divisor_neg;
    logic [WORD_WIDTH-1:0] dividend_mag, divisor_mag;
    logic                  zero_div, signed_ovf;
    logic [WORD_WIDTH:0]   shifted, part_next;
    logic [WORD_WIDTH-1:0] quo_next, rem_fix, quo_final, rem_final;

    assign accept       = in_valid && in_ready;
    assign dividend_neg = is_signed && dividend[WORD_WIDTH-1];
    assign divisor_neg  = is_signed && divisor[WORD_WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg ? -divisor : divisor;
    assign zero_div     = (divisor == '0);
    assign signed_ovf   = is_signed && (dividend == MostNeg) && (divisor == '1);

    // Partial remainder stays within (-D, D), so W+1 bits with wraparound suffice.
    assign shifted   = {part_q[WORD_WIDTH-1:0], quo_q[WORD_WIDTH-1]};
    assign part_next = part_q[WORD_WIDTH] ? shifted + {1'b0, dvs_q} : shifted - {1'b0, dvs_q};
    assign quo_next  = {quo_q[WORD_WIDTH-2:0], ~part_next[WORD_WIDTH]};

    assign rem_fix   = part_q[WORD_WIDTH] ? part_q[WORD_WIDTH-1:0] + dvs_q
                                          : part_q[WORD_WIDTH-1:0];
    assign quo_final = neg_quo_q ? -quo_q : quo_q;
    assign rem_final = neg_rem_q ? -rem_fix : rem_fix;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = (zero_div || signed_ovf) ? StDone : StRun;
            StRun:  if (cnt_q == CntW'(1)) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && ready_q;
        out_valid = (state_q == StDone);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            part_q     <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // Holds in_ready low until the first edge after reset release.
            ready_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (zero_div) begin
                            quot_res_q <= '1;
                            rem_res_q  <= dividend;
                            dbz_q      <= 1'b1;
                            ovf_q      <= 1'b0;
                        end else if (signed_ovf) begin
                            quot_res_q <= dividend;
                            rem_res_q  <= '0;
                            dbz_q      <= 1'b0;
                            ovf_q      <= 1'b1;
                        end else begin
                            part_q    <= '0;
                            quo_q     <= dividend_mag;
                            dvs_q     <= divisor_mag;
                            cnt_q     <= IterCount;
                            neg_quo_q <= dividend_neg ^ divisor_neg;
                            neg_rem_q <= dividend_neg;
                        end
                    end
                end
                StRun: begin
                    part_q <= part_next;
                    quo_q  <= quo_next;
                    cnt_q  <= cnt_q - CntW'(1);
                end
                StFix: begin
                    quot_res_q <= quo_final;
                    rem_res_q  <= rem_final;
                    dbz_q      <= 1'b0;
                    ovf_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quot_res_q;
    assign remainder   = rem_res_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_signed_iterative.sv
// Directed self-checking bench for divider_signed_iterative at WORD_WIDTH=8.
module tb_divider_signed_iterative;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready;
    logic [W-1:0] dividend, divisor;
    logic         is_signed;
    logic         out_valid, out_ready;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero, overflow;

    int checks = 0;
    int errors = 0;

    divider_signed_iterative #(.WORD_WIDTH(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation, check latency/results, hold DONE for 'hold' cycles, then retire it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eov, input int elat, input int hold);
        int lat;
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        in_valid  = 1'b1;
        tick();
        // Scramble inputs after accept; the latched operands must be used.
        in_valid  = 1'b0;
        dividend  = ~a;
        divisor   = 8'h00;
        is_signed = ~sgn;
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " flags"}, {30'd0, div_by_zero, overflow}, {30'd0, edz, eov});
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold"}, {out_valid, in_ready, div_by_zero, overflow, quotient, remainder},
                  {1'b1, 1'b0, edz, eov, eq, er});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " retire"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int seen_valid;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        tick();
        tick();
        check("reset outputs", {in_ready, out_valid, div_by_zero, overflow, quotient, remainder},
              32'd0);
        reset_n = 1'b1;
        tick();
        check("ready after reset", 32'(in_ready), 32'd1);

        run_op("u 100/7",     8'd100, 8'd7,   1'b0, 8'd14,  8'd2,  1'b0, 1'b0, 10, 0);
        run_op("s -7/2",      8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0, 10, 0);
        run_op("s 7/-2",      8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01, 1'b0, 1'b0, 10, 0);
        run_op("u dbz",       8'h55,  8'h00,  1'b0, 8'hFF,  8'h55, 1'b1, 1'b0, 1,  0);
        run_op("s dbz",       8'h55,  8'h00,  1'b1, 8'hFF,  8'h55, 1'b1, 1'b0, 1,  0);
        run_op("s ovf",       8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0, 1'b1, 1,  0);
        run_op("u 128/255",   8'h80,  8'hFF,  1'b0, 8'h00,  8'h80, 1'b0, 1'b0, 10, 0);
        run_op("u 255/254",   8'hFF,  8'hFE,  1'b0, 8'h01,  8'h01, 1'b0, 1'b0, 10, 0);
        run_op("s -128/2",    8'h80,  8'h02,  1'b1, 8'hC0,  8'h00, 1'b0, 1'b0, 10, 0);
        run_op("s -128/127",  8'h80,  8'h7F,  1'b1, 8'hFF,  8'hFF, 1'b0, 1'b0, 10, 0);
        run_op("s -9/-4",     8'hF7,  8'hFC,  1'b1, 8'h02,  8'hFF, 1'b0, 1'b0, 10, 0);
        run_op("u 3/10",      8'd3,   8'd10,  1'b0, 8'd0,   8'd3,  1'b0, 1'b0, 10, 0);
        run_op("bp 200/7",    8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0, 1'b0, 10, 5);
        run_op("after bp",    8'd50,  8'd6,   1'b0, 8'd8,   8'd2,  1'b0, 1'b0, 10, 0);

        // Abort an operation with reset in its fourth RUN cycle.
        dividend  = 8'd90;
        divisor   = 8'd4;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid reset outputs",
              {in_ready, out_valid, div_by_zero, overflow, quotient, remainder}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("ready after mid reset", 32'(in_ready), 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        check("no stale out_valid", 32'(seen_valid), 32'd0);
        run_op("u 200/3",     8'd200, 8'd3,   1'b0, 8'd66,  8'd2,  1'b0, 1'b0, 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
